// File: rtl/ccff_chain_loader_if.sv
// Bitstream word handshake between the configuration source and the chain loader.
// The source owns start/abort/word_in/word_valid; the loader answers with word_ready.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output start,
        output abort,
        output word_in,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  start,
        input  abort,
        input  word_in,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Word-to-serial configuration loader: shifts words MSB first into a chain, then
// commits the whole chain to the TGATE sel/selb shadow outputs in one cycle.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic                 prog_clk,
    input  logic                 prog_rst_n,
    ccff_chain_loader_if.slave   bus,
    output logic [CHAIN_LEN-1:0] mem_out,
    output logic [CHAIN_LEN-1:0] mem_outb,
    output logic                 ccff_tail,
    output logic                 busy,
    output logic                 done
);
    localparam int WORDS  = CHAIN_LEN / WORD_W;
    localparam int BIT_W  = $clog2(WORD_W);
    localparam int WCNT_W = $clog2(WORDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t               state_r;
    state_t               next_state_s;
    logic [CHAIN_LEN-1:0] shift_r;
    logic [CHAIN_LEN-1:0] mem_r;
    logic [WORD_W-1:0]    word_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic [WCNT_W-1:0]    word_cnt_r;
    logic                 ready_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 last_bit_s;
    logic                 last_word_s;
    logic                 clear_cnt_s;
    logic                 capture_s;
    logic                 shift_en_s;
    logic                 commit_s;
    logic                 ready_d_s;
    logic                 busy_d_s;

    assign last_bit_s  = (bit_cnt_r == BIT_W'(WORD_W - 1));
    assign last_word_s = (word_cnt_r == WCNT_W'(WORDS - 1));

    // State register.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; abort overrides every other transition out of a busy state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    next_state_s = ST_IDLE;
                end else if (bus.word_valid) begin
                    next_state_s = ST_SHIFT;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    next_state_s = ST_IDLE;
                end else if (last_bit_s) begin
                    next_state_s = last_word_s ? ST_COMMIT : ST_LOAD;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_COMMIT: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output/control decode; status flags are derived from the next state so they register cleanly.
    always_comb begin
        clear_cnt_s = 1'b0;
        capture_s   = 1'b0;
        shift_en_s  = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE:   clear_cnt_s = bus.start && !bus.abort;
            ST_LOAD:   capture_s   = bus.word_valid && !bus.abort;
            ST_SHIFT:  shift_en_s  = !bus.abort;
            ST_COMMIT: commit_s    = !bus.abort;
            default: begin
                clear_cnt_s = 1'b0;
                capture_s   = 1'b0;
                shift_en_s  = 1'b0;
                commit_s    = 1'b0;
            end
        endcase
        ready_d_s = (next_state_s == ST_LOAD);
        busy_d_s  = (next_state_s != ST_IDLE);
    end

    // Datapath: word capture, serial shift, counters and the single-cycle commit.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            shift_r    <= {CHAIN_LEN{1'b0}};
            mem_r      <= {CHAIN_LEN{1'b0}};
            word_r     <= {WORD_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            word_cnt_r <= {WCNT_W{1'b0}};
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            ready_r <= ready_d_s;
            busy_r  <= busy_d_s;
            done_r  <= commit_s;
            if (clear_cnt_s) begin
                word_cnt_r <= {WCNT_W{1'b0}};
            end else if (shift_en_s && last_bit_s) begin
                word_cnt_r <= word_cnt_r + WCNT_W'(1);
            end else begin
                word_cnt_r <= word_cnt_r;
            end
            if (capture_s) begin
                word_r    <= bus.word_in;
                bit_cnt_r <= {BIT_W{1'b0}};
            end else if (shift_en_s) begin
                word_r    <= {word_r[WORD_W-2:0], 1'b0};
                bit_cnt_r <= last_bit_s ? bit_cnt_r : bit_cnt_r + BIT_W'(1);
            end else begin
                word_r    <= word_r;
                bit_cnt_r <= bit_cnt_r;
            end
            if (shift_en_s) begin
                shift_r <= {shift_r[CHAIN_LEN-2:0], word_r[WORD_W-1]};
            end else begin
                shift_r <= shift_r;
            end
            if (commit_s) begin
                mem_r <= shift_r;
            end else begin
                mem_r <= mem_r;
            end
        end
    end

    // selb is the inverse of the same register, so sel/selb can never disagree.
    assign mem_out        = mem_r;
    assign mem_outb       = ~mem_r;
    assign ccff_tail      = shift_r[CHAIN_LEN-1];
    assign busy           = busy_r;
    assign done           = done_r;
    assign bus.word_ready = ready_r;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized scenario bench for ccff_chain_loader (CHAIN_LEN=16, WORD_W=8) against a
// bitstream-level reference model.
module tb_ccff_chain_loader;
    localparam int CL = 16;
    localparam int WW = 8;

    logic          prog_clk;
    logic          prog_rst_n;
    logic [CL-1:0] mem_out;
    logic [CL-1:0] mem_outb;
    logic          ccff_tail;
    logic          busy;
    logic          done;

    ccff_chain_loader_if #(.WORD_W(WW)) bus ();

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .bus        (bus),
        .mem_out    (mem_out),
        .mem_outb   (mem_outb),
        .ccff_tail  (ccff_tail),
        .busy       (busy),
        .done       (done)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    int            vectors = 0;
    int            errors  = 0;
    logic [CL-1:0] mem_exp;
    logic [CL-1:0] prev_sr;

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // One full load of two words. stall: LOAD cycles withheld before word 1.
    // abort_at: number of bits already shifted when abort is raised (16 = in COMMIT, -1 = never).
    task automatic do_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                           input int stall, input int abort_at, input bit noise);
        logic [2*CL-1:0] full;
        logic [WW-1:0]   w [2];
        int              n;
        int              cyc;
        w[0] = w0;
        w[1] = w1;
        full = {prev_sr, w0, w1};
        n    = 0;
        cyc  = 0;
        vectors++;
        if ({busy, done, bus.word_ready} !== 3'b000) begin
            errors++;
            $display("FAIL idle_status got=%b want=000", {busy, done, bus.word_ready});
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < ((i == 1) ? stall : 0); s++) begin
                bus.word_valid = 1'b0;
                bus.word_in    = WW'($urandom);
                vectors++;
                if ({busy, bus.word_ready, done} !== 3'b110) begin
                    errors++;
                    $display("FAIL stall_status cyc=%0d got=%b want=110", cyc, {busy, bus.word_ready, done});
                end
                tick();
                cyc++;
            end
            vectors++;
            if ({busy, bus.word_ready, done} !== 3'b110) begin
                errors++;
                $display("FAIL load_status word=%0d got=%b want=110", i, {busy, bus.word_ready, done});
            end
            bus.word_valid = 1'b1;
            bus.word_in    = w[i];
            tick();
            cyc++;
            bus.word_valid = noise ? 1'($urandom) : 1'b0;
            bus.word_in    = WW'($urandom);
            for (int b = 0; b < WW; b++) begin
                if (noise) begin
                    bus.start      = 1'($urandom);
                    bus.word_valid = 1'($urandom);
                end
                vectors++;
                if ({busy, bus.word_ready, done, ccff_tail} !== {3'b100, full[2*CL-1-n]}) begin
                    errors++;
                    $display("FAIL shift_status n=%0d got=%b want=%b", n, {busy, bus.word_ready, done, ccff_tail},
                             {3'b100, full[2*CL-1-n]});
                end
                if (n == abort_at) begin
                    bus.abort      = 1'b1;
                    bus.start      = 1'b0;
                    bus.word_valid = 1'b0;
                    tick();
                    bus.abort = 1'b0;
                    prev_sr   = full[2*CL-1-n -: CL];
                    vectors++;
                    if ({busy, bus.word_ready, done, mem_out, mem_outb, ccff_tail} !==
                        {3'b000, mem_exp, ~mem_exp, prev_sr[CL-1]}) begin
                        errors++;
                        $display("FAIL abort_shift n=%0d got mem=%h bd=%b want mem=%h", n, mem_out,
                                 {busy, bus.word_ready, done}, mem_exp);
                    end
                    return;
                end
                tick();
                n++;
                cyc++;
            end
            bus.start      = 1'b0;
            bus.word_valid = 1'b0;
        end
        vectors++;
        if ({busy, bus.word_ready, done, mem_out} !== {3'b100, mem_exp}) begin
            errors++;
            $display("FAIL pre_commit got mem=%h bd=%b want mem=%h bd=100", mem_out, {busy, bus.word_ready, done}, mem_exp);
        end
        prev_sr = full[CL-1:0];
        if (abort_at == CL) begin
            bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
            vectors++;
            if ({busy, done, mem_out, mem_outb} !== {2'b00, mem_exp, ~mem_exp}) begin
                errors++;
                $display("FAIL abort_commit got mem=%h done=%b want mem=%h done=0", mem_out, done, mem_exp);
            end
            return;
        end
        tick();
        cyc++;
        mem_exp = {w0, w1};
        vectors++;
        if ({done, busy, bus.word_ready, mem_out, mem_outb} !== {3'b100, mem_exp, ~mem_exp} ||
            cyc != (CL / WW) * (WW + 1) + 1 + stall) begin
            errors++;
            $display("FAIL commit got mem=%h memb=%h done=%b cyc=%0d want mem=%h cyc=%0d", mem_out, mem_outb, done,
                     cyc, mem_exp, (CL / WW) * (WW + 1) + 1 + stall);
        end
        tick();
        vectors++;
        if ({done, busy, mem_out} !== {2'b00, mem_exp}) begin
            errors++;
            $display("FAIL done_pulse got done=%b busy=%b mem=%h want 0 0 %h", done, busy, mem_out, mem_exp);
        end
    endtask

    task automatic test_reset();
        prog_rst_n     = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_in    = '0;
        #1 prog_rst_n = 1'b0;
        #1;
        mem_exp = '0;
        prev_sr = '0;
        vectors++;
        if ({mem_out, mem_outb, busy, bus.word_ready, done, ccff_tail} !== {16'h0000, 16'hFFFF, 4'b0000}) begin
            errors++;
            $display("FAIL reset_initial got mem=%h memb=%h flags=%b", mem_out, mem_outb,
                     {busy, bus.word_ready, done, ccff_tail});
        end
        tick();
        tick();
        prog_rst_n = 1'b1;
        tick();
        // Load a first word and reset asynchronously in the middle of its shifts.
        bus.start = 1'b1;
        tick();
        bus.start      = 1'b0;
        bus.word_valid = 1'b1;
        bus.word_in    = 8'hFF;
        tick();
        bus.word_valid = 1'b0;
        tick();
        tick();
        tick();
        #2 prog_rst_n = 1'b0;
        #1;
        vectors++;
        if ({mem_out, mem_outb, busy, bus.word_ready, done, ccff_tail} !== {16'h0000, 16'hFFFF, 4'b0000}) begin
            errors++;
            $display("FAIL reset_mid_shift got mem=%h memb=%h flags=%b", mem_out, mem_outb,
                     {busy, bus.word_ready, done, ccff_tail});
        end
        tick();
        prog_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if ({busy, bus.word_ready, done, mem_out} !== {3'b000, 16'h0000}) begin
                errors++;
                $display("FAIL reset_release k=%0d got flags=%b mem=%h", k, {busy, bus.word_ready, done}, mem_out);
            end
        end
    endtask

    task automatic test_basic();
        do_load(8'hA5, 8'h3C, 0, -1, 1'b0);
        vectors++;
        if (mem_out !== 16'hA53C || mem_outb !== 16'h5AC3) begin
            errors++;
            $display("FAIL basic_value got mem=%h memb=%h want a53c 5ac3", mem_out, mem_outb);
        end
    endtask

    task automatic test_bit_order();
        do_load(8'h01, 8'h80, 0, -1, 1'b0);
        vectors++;
        if (mem_out !== 16'h0180) begin
            errors++;
            $display("FAIL bit_order got mem=%h want 0180", mem_out);
        end
        do_load(8'h80, 8'h01, 0, -1, 1'b0);
    endtask

    task automatic test_stall();
        do_load(8'hA5, 8'h3C, 5, -1, 1'b0);
    endtask

    task automatic test_abort();
        do_load(8'hA5, 8'h3C, 0, -1, 1'b0);
        do_load(8'hFF, 8'hFF, 0, 1, 1'b0);
        tick();
        vectors++;
        if ({busy, done, mem_out} !== {2'b00, 16'hA53C}) begin
            errors++;
            $display("FAIL abort_hold got busy=%b done=%b mem=%h want 0 0 a53c", busy, done, mem_out);
        end
        do_load(8'h12, 8'h34, 0, CL, 1'b0);
        // start together with abort in IDLE must not leave IDLE.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        vectors++;
        if ({busy, bus.word_ready} !== 2'b00) begin
            errors++;
            $display("FAIL start_abort_idle got busy=%b ready=%b want 0 0", busy, bus.word_ready);
        end
        // Abort while waiting in LOAD.
        bus.start = 1'b1;
        tick();
        bus.start      = 1'b0;
        bus.abort      = 1'b1;
        bus.word_valid = 1'b1;
        bus.word_in    = 8'h77;
        tick();
        bus.abort      = 1'b0;
        bus.word_valid = 1'b0;
        vectors++;
        if ({busy, bus.word_ready, done, mem_out, ccff_tail} !== {3'b000, mem_exp, prev_sr[CL-1]}) begin
            errors++;
            $display("FAIL abort_load got flags=%b mem=%h want 000 %h", {busy, bus.word_ready, done}, mem_out, mem_exp);
        end
    endtask

    task automatic test_ignored();
        do_load(WW'($urandom), WW'($urandom), 0, -1, 1'b1);
        do_load(WW'($urandom), WW'($urandom), 2, -1, 1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, CL)) : -1;
            do_load(WW'($urandom), WW'($urandom), int'($urandom_range(0, 3)), ab, 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bit_order();
        test_stall();
        test_abort();
        test_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Word-to-serial configuration loader that drives the select network of the routing fabric. It accepts a bitstream as WORD_W-bit words over a valid/ready handshake and shifts them, MSB first, into an internal CHAIN_LEN-bit configuration chain. On the last word it commits the chain to shadow outputs mem_out/mem_outb in a single cycle. Those outputs feed the sel/selb pins of the transmission-gate multiplexers, so routing never observes a partially shifted pattern.

## Interface
Parameters:
- CHAIN_LEN, 64: configuration bits; must be a multiple of WORD_W.
- WORD_W, 8: bitstream word width. WORDS = CHAIN_LEN/WORD_W.

Ports:
- prog_clk  in  1  programming clock, rising edge.
- prog_rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- start  in  1  begin a load; sampled in IDLE only.
- abort  in  1  cancel the load in progress; the outputs keep their previous value.
- word_in  in  WORD_W  bitstream word.
- word_valid  in  1  word_in is valid.
- word_ready  out  1  loader accepts word_in this cycle.
- mem_out  out  CHAIN_LEN  committed configuration (TGATE sel).
- mem_outb  out  CHAIN_LEN  bitwise complement of mem_out (TGATE selb).
- ccff_tail  out  1  shift_reg[CHAIN_LEN-1], for daisy-chaining and readback.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse, coincident with the commit.

## Operation
- States: IDLE, LOAD, SHIFT, COMMIT.
- IDLE: start=1 and abort=0 → LOAD; word counter cleared.
- LOAD: word_ready=1. On word_valid=1, capture word_in into the word register → SHIFT with bit counter=0.
- SHIFT: each cycle, shift_reg <= {shift_reg[CHAIN_LEN-2:0], word_reg[WORD_W-1]} and word_reg shifts left by 1.
  - After WORD_W shifts, the word counter increments.
  - If the counter equals WORDS → COMMIT; otherwise → LOAD.
- COMMIT: mem_out <= shift_reg, mem_outb <= ~shift_reg, done <= 1 → IDLE.
- Resulting layout: the first word loaded occupies mem_out[CHAIN_LEN-1 -: WORD_W], and the last word occupies mem_out[WORD_W-1:0].
- mem_out and mem_outb come from the same registered source and change only in the COMMIT update. mem_outb == ~mem_out at all times, including during reset.
- abort=1 in LOAD, SHIFT or COMMIT → IDLE on the next edge.
  - Abort has priority over word acceptance and over commit.
  - mem_out is unchanged, done is not pulsed, and shift_reg keeps its partial contents.
- start while busy is ignored. start with abort in IDLE: abort wins and the state stays IDLE.
- word_valid outside LOAD is ignored. No words are lost or reordered because word_ready is low there.
- Counters: bit counter is clog2(WORD_W) bits wide; word counter is clog2(WORDS+1) bits wide. Neither wraps within a load.

## Timing
- Reset (asynchronous assert, synchronous release) sets the following:
  - State IDLE.
  - shift_reg=0, mem_out=0, mem_outb=all ones.
  - word_ready=0, busy=0, done=0, ccff_tail=0.
- Reset mid-load returns to this same state. All routing selects go inactive.
- Edge numbering: start is sampled at edge E0 → LOAD after E0.
- Per word: 1 LOAD cycle (minimum) plus WORD_W SHIFT cycles.
- With word_valid held high, commit occurs at edge E0 + WORDS*(WORD_W+1) + 1.
  - At that edge, mem_out updates and done rises.
  - done falls at the next edge.
- Stalls: each cycle word_valid stays low in LOAD adds one cycle. word_ready stays high while stalled.
- word_ready is registered from state and is never high in SHIFT, COMMIT or IDLE.

## Test plan
All scenarios use CHAIN_LEN=16, WORD_W=8.
- Reset: assert prog_rst_n=0 mid-SHIFT → immediately mem_out=0x0000, mem_outb=0xFFFF, busy=0, word_ready=0. After release, idle with no done pulse.
- Basic load: start, then words 0xA5, 0x3C with valid held high → at E0+19, mem_out=0xA53C, mem_outb=0x5AC3, done=1 for exactly one cycle, busy=0 afterwards.
- Bit order: words 0x01, 0x80 → mem_out=0x0180. ccff_tail reads 1 while shift_reg[15]=1 during the second word's shifts.
- Stall: withhold word_valid for 5 cycles before the second word → commit at E0+24 with the same data. word_ready stays high throughout the stall.
- Abort: load 0xA5,0x3C, then start a new load of 0xFF,0xFF and assert abort during its second SHIFT → mem_out remains 0xA53C, no done pulse, busy=0 next cycle.
- Ignored inputs: start pulsed during SHIFT and word_valid pulsed during SHIFT → no state change, no extra word accepted, final mem_out is as expected.
